// File: rtl/elastic_async_operator.sv
// elastic_async_operator: an N-input arithmetic dataflow operator.
// Operands are pulled from upstream with a req/ack handshake, one slot per input.
// Results are written into a shared circular buffer. Each consumer reads the
// buffer through its own pointer, so one consumer can run ahead of another.
// A new result is only blocked when the slowest consumer is a full buffer behind.
// The buffer can be preloaded with tokens at reset, for loop-carried graphs.
// err is a sticky flag. It is set when an input acks while its slot is still full.
module elastic_async_operator #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    NUM_IN      = 2,
    parameter int                    NUM_OUT     = 1,
    parameter int                    DEPTH       = 4,
    parameter string                 OP          = "add",
    parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
    parameter int                    INIT_TOKENS = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE  = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic [NUM_IN-1:0]               req_l,
    input  logic [NUM_IN-1:0]               ack_l,
    input  logic [NUM_IN*DATA_WIDTH-1:0]    din,
    input  logic [NUM_OUT-1:0]              req_r,
    output logic [NUM_OUT-1:0]              ack_r,
    output logic [NUM_OUT*DATA_WIDTH-1:0]   dout,
    output logic                            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [NUM_IN-1:0]     has;
    logic [NUM_IN-1:0]     has_nxt;
    logic [DATA_WIDTH-1:0] opnd [NUM_IN];
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr [NUM_OUT];
    logic [PW-1:0]         cnt [NUM_OUT];
    logic                  full;
    logic                  fire;
    logic [DATA_WIDTH-1:0] result;

    // Per-consumer occupancy. One lagging consumer is enough to stall the producer.
    always_comb begin
        full = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            cnt[j] = wr_ptr - rd_ptr[j];
            if (cnt[j] == PW'(DEPTH)) full = 1'b1;
        end
    end

    // Fire uses the occupancy from before the edge. A pop on the same edge does not unblock it.
    assign fire = (&has) & ~full;

    // Next operand-slot occupancy. A slot empties on fire and fills on ack.
    always_comb begin
        has_nxt = has;
        for (int i = 0; i < NUM_IN; i++) begin
            if (fire)          has_nxt[i] = 1'b0;
            else if (ack_l[i]) has_nxt[i] = 1'b1;
        end
    end

    // Operation applied to the captured operands. Unsigned, truncated to DATA_WIDTH.
    always_comb begin
        result = opnd[0];
        if (OP == "add") begin
            for (int i = 1; i < NUM_IN; i++) result = result + opnd[i];
        end else if (OP == "sub") begin
            for (int i = 1; i < NUM_IN; i++) result = result - opnd[i];
        end else if (OP == "mul") begin
            for (int i = 1; i < NUM_IN; i++) result = result * opnd[i];
        end else if (OP == "min") begin
            for (int i = 1; i < NUM_IN; i++) if (opnd[i] < result) result = opnd[i];
        end else if (OP == "max") begin
            for (int i = 1; i < NUM_IN; i++) if (opnd[i] > result) result = opnd[i];
        end else if (OP == "addi") begin
            result = opnd[0] + IMMEDIATE;
        end else if (OP == "subi") begin
            result = opnd[0] - IMMEDIATE;
        end else if (OP == "muli") begin
            result = opnd[0] * IMMEDIATE;
        end
    end

    // Input side: operand capture, the request to upstream, and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has   <= '0;
            req_l <= '0;
            err   <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) opnd[i] <= '0;
        end else begin
            has   <= has_nxt;
            req_l <= ~has_nxt;
            for (int i = 0; i < NUM_IN; i++) begin
                if (ack_l[i] && !has[i]) opnd[i] <= din[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (|(ack_l & has)) err <= 1'b1;
        end
    end

    // Result buffer and write pointer. Reset reloads any preloaded tokens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= PW'(INIT_TOKENS);
            for (int k = 0; k < DEPTH; k++) mem[k] <= (k < INIT_TOKENS) ? INIT_VALUE : '0;
        end else if (fire) begin
            mem[wr_ptr[AW-1:0]] <= result;
            wr_ptr              <= wr_ptr + 1'b1;
        end
    end

    // Output side: each consumer gets at most one token every other cycle, from its own read pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_r <= '0;
            dout  <= '0;
            for (int j = 0; j < NUM_OUT; j++) rd_ptr[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (req_r[j] && !ack_r[j] && cnt[j] != '0) begin
                    ack_r[j]                            <= 1'b1;
                    dout[j*DATA_WIDTH +: DATA_WIDTH]    <= mem[rd_ptr[j][AW-1:0]];
                    rd_ptr[j]                           <= rd_ptr[j] + 1'b1;
                end else begin
                    ack_r[j] <= 1'b0;
                end
            end
        end
    end

endmodule
